// File: rtl/cpu_pkg.sv
// Shared encodings and control types for the single-cycle MIPS-subset core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to zero.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0][31:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   regs     <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: decode, ALU and next-PC are combinational; PC and
// register file update on the rising edge.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_read,
  output logic        mem_write
);

  logic [31:0] pc, pc_plus4, next_pc;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_y, wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic        unused_shamt;
  ctrl_t       ctrl;

  assign op           = instruction[31:26];
  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  assign funct        = instruction[5:0];
  assign unused_shamt = ^instruction[10:6];
  assign imm_ext      = sext16(instruction[15:0]);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst_rd = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OP_BEQ:  ctrl.branch = 1'b1;
      OP_J:    ctrl.jump   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = rs_val + alu_b;
    case (ctrl.alu_op)
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: ;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jump)
      next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
    else if (ctrl.branch && rs_val == rt_val)
      next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  assign wa = ctrl.reg_dst_rd ? rd : rt;
  assign wd = ctrl.mem_read ? data_in : alu_y;

  // Gating with rst keeps an edge during reset from committing anything.
  cpu_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .we  (ctrl.reg_write & ~rst),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  assign instruction_addr = pc;
  assign data_addr        = alu_y;
  assign data_out         = rt_val;
  assign mem_read         = ctrl.mem_read & ~rst;
  assign mem_write        = ctrl.mem_write & ~rst;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: stimulus pushes the expected per-cycle trace, a monitor
// pops one entry per executed instruction and compares PC and data-port activity.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] instruction_addr, instruction, data_addr, data_in, data_out;
  logic        mem_read, mem_write;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  localparam logic [1:0] K_NONE = 2'd0, K_LD = 2'd1, K_ST = 2'd2;
  localparam logic [31:0] SENT  = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_addr (instruction_addr),
    .instruction      (instruction),
    .data_addr        (data_addr),
    .data_in          (data_in),
    .data_out         (data_out),
    .mem_read         (mem_read),
    .mem_write        (mem_write)
  );

  always #5 clk = ~clk;

  assign instruction = imem[instruction_addr[9:2]];
  assign data_in     = dmem[data_addr[9:2]];

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= SENT + 32'(i);
    end else if (mem_write) begin
      dmem[data_addr[9:2]] <= data_out;
    end
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] kind,
                      input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.pc = pc; e.kind = kind; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d trace entries left, expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: one sample per cycle, 3 ns before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && q.size() != 0) begin
        me = q.pop_front();
        chk($sformatf("pc@%h", me.pc), instruction_addr, me.pc);
        chk($sformatf("mem_read@%h", me.pc), {31'd0, mem_read}, {31'd0, me.kind == K_LD});
        chk($sformatf("mem_write@%h", me.pc), {31'd0, mem_write}, {31'd0, me.kind == K_ST});
        if (me.kind != K_NONE) chk($sformatf("data_addr@%h", me.pc), data_addr, me.addr);
        if (me.kind == K_ST)   chk($sformatf("data_out@%h", me.pc), data_out, me.data);
      end
    end
  end

  initial begin
    #1 clr = 1'b1;
    #1 clr = 1'b0;

    // ALU sequence, r0 protection, unknown funct/opcode as nop
    clear_imem();
    imem[0]  = i_ins(6'h2B, 5'd0, 5'd0, 16'h0000);
    imem[1]  = i_ins(6'h08, 5'd0, 5'd1, 16'h0005);
    imem[2]  = i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[3]  = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
    imem[4]  = r_ins(5'd1, 5'd2, 5'd4, 6'h22);
    imem[5]  = r_ins(5'd1, 5'd2, 5'd5, 6'h24);
    imem[6]  = r_ins(5'd1, 5'd2, 5'd6, 6'h25);
    imem[7]  = r_ins(5'd2, 5'd1, 5'd7, 6'h2A);
    imem[8]  = i_ins(6'h2B, 5'd0, 5'd3, 16'h0100);
    imem[9]  = i_ins(6'h2B, 5'd0, 5'd4, 16'h0104);
    imem[10] = i_ins(6'h2B, 5'd0, 5'd5, 16'h0108);
    imem[11] = i_ins(6'h2B, 5'd0, 5'd6, 16'h010C);
    imem[12] = i_ins(6'h2B, 5'd0, 5'd7, 16'h0110);
    imem[13] = i_ins(6'h08, 5'd0, 5'd0, 16'h0007);
    imem[14] = r_ins(5'd0, 5'd0, 5'd1, 6'h20);
    imem[15] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0114);
    imem[16] = r_ins(5'd7, 5'd7, 5'd1, 6'h3F);
    imem[17] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0118);
    imem[18] = i_ins(6'h3F, 5'd7, 5'd1, 16'h0001);
    imem[19] = i_ins(6'h2B, 5'd0, 5'd1, 16'h011C);
    imem[20] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);

    push(32'h00, K_ST, 32'h0, 32'h0);
    for (int a = 4; a <= 32'h1C; a += 4) push(32'(a), K_NONE, 32'h0, 32'h0);
    push(32'h20, K_ST, 32'h100, 32'h2);
    push(32'h24, K_ST, 32'h104, 32'h8);
    push(32'h28, K_ST, 32'h108, 32'h5);
    push(32'h2C, K_ST, 32'h10C, 32'hFFFF_FFFD);
    push(32'h30, K_ST, 32'h110, 32'h1);
    push(32'h34, K_NONE, 32'h0, 32'h0);
    push(32'h38, K_NONE, 32'h0, 32'h0);
    push(32'h3C, K_ST, 32'h114, 32'h0);
    push(32'h40, K_NONE, 32'h0, 32'h0);
    push(32'h44, K_ST, 32'h118, 32'h0);
    push(32'h48, K_NONE, 32'h0, 32'h0);
    push(32'h4C, K_ST, 32'h11C, 32'h0);
    push(32'h50, K_NONE, 32'h0, 32'h0);
    push(32'h50, K_NONE, 32'h0, 32'h0);

    #3 rst = 1'b1;                                   // t = 5
    #2;                                              // t = 7, sw sits at PC 0
    chk("reset_pc", instruction_addr, 32'h0);
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
    #3 rst = 1'b0;                                   // t = 10
    wait_done("alu");

    // Memory and control flow
    rst = 1'b1;
    clear_imem();
    imem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'h0040);
    imem[1]  = i_ins(6'h08, 5'd0, 5'd2, 16'h1234);
    imem[2]  = i_ins(6'h2B, 5'd1, 5'd2, 16'h0004);
    imem[3]  = i_ins(6'h23, 5'd1, 5'd3, 16'h0004);
    imem[4]  = i_ins(6'h04, 5'd0, 5'd0, 16'h0002);
    imem[5]  = i_ins(6'h08, 5'd0, 5'd3, 16'h0077);
    imem[6]  = i_ins(6'h08, 5'd0, 5'd3, 16'h0077);
    imem[7]  = {6'h02, 26'h10};
    imem[16] = i_ins(6'h04, 5'd1, 5'd0, 16'h0005);
    imem[17] = i_ins(6'h2B, 5'd0, 5'd3, 16'h0080);
    imem[18] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
    push(32'h00, K_NONE, 32'h0, 32'h0);
    push(32'h04, K_NONE, 32'h0, 32'h0);
    push(32'h08, K_ST, 32'h44, 32'h1234);
    push(32'h0C, K_LD, 32'h44, 32'h0);
    push(32'h10, K_NONE, 32'h0, 32'h0);
    push(32'h1C, K_NONE, 32'h0, 32'h0);
    push(32'h40, K_NONE, 32'h0, 32'h0);
    push(32'h44, K_ST, 32'h80, 32'h1234);
    push(32'h48, K_NONE, 32'h0, 32'h0);
    push(32'h48, K_NONE, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("mem_ctrl");

    // Reset pulsed while a sw is executing
    rst = 1'b1;
    clear_imem();
    imem[0] = i_ins(6'h2B, 5'd2, 5'd1, 16'h0000);
    imem[1] = i_ins(6'h08, 5'd0, 5'd1, 16'h0055);
    imem[2] = i_ins(6'h08, 5'd0, 5'd2, 16'h0020);
    imem[3] = i_ins(6'h2B, 5'd2, 5'd1, 16'h0000);
    imem[4] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
    push(32'h00, K_ST, 32'h0, 32'h0);
    push(32'h04, K_NONE, 32'h0, 32'h0);
    push(32'h08, K_NONE, 32'h0, 32'h0);
    push(32'h0C, K_ST, 32'h20, 32'h55);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("pre_abort");
    rst = 1'b1;                                      // before the sw's edge
    @(posedge clk);
    #1;
    chk("abort_pc", instruction_addr, 32'h0);
    chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
    chk("abort_r1_zero", data_out, 32'h0);
    chk("abort_r2_zero", data_addr, 32'h0);
    chk("abort_no_store", dmem[8], SENT + 32'd8);
    push(32'h00, K_ST, 32'h0, 32'h0);
    push(32'h04, K_NONE, 32'h0, 32'h0);
    push(32'h08, K_NONE, 32'h0, 32'h0);
    push(32'h0C, K_ST, 32'h20, 32'h55);
    push(32'h10, K_NONE, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("post_abort");
    @(posedge clk);
    #1;
    chk("store_landed", dmem[8], 32'h55);
    chk("load_store_mem", dmem[17], 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Single-cycle 32-bit MIPS-subset processor core. It fetches from an instruction port and executes one instruction per clock. Loads and stores go through a separate combinational data port. The core sits beside a Harvard-style memory model that returns instruction and load data in the same cycle an address is presented.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address fetched after reset.

Ports:
- clk  input  1  system clock; the only clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- instruction_addr  output  32  byte address of the current instruction (the PC).
- instruction  input  32  instruction word at instruction_addr, valid in the same cycle.
- data_addr  output  32  byte address for a load or store (ALU result).
- data_in  input  32  load data returned by memory for data_addr, same cycle.
- data_out  output  32  store data (rt register value).
- mem_read  output  1  high while executing lw.
- mem_write  output  1  high while executing sw; memory writes on the rising clk edge.

## Operation
- Supported ISA, MIPS encodings:
  - R-type (op 0), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi (op 0x08), lw (0x23), sw (0x2B), beq (0x04), j (0x02).
- Unknown opcode or funct executes as a nop: no register write, no memory access, PC+4.
- Register file: 32 x 32-bit, two combinational read ports and one write port. r0 always reads 0, and writes to it are discarded.
- Arithmetic:
  - add, sub and addi are two's-complement and wrap modulo 2^32; there is no overflow trap.
  - slt is a signed compare that writes 1 or 0.
- Immediates are sign-extended 16 to 32 bits.
- Write destination is rd for R-type and rt for addi and lw.
- lw/sw address = rs + sext(imm). Addresses are byte addresses; the core does not check alignment.
- Next PC:
  - default is PC+4.
  - beq taken (rs == rt): PC+4 + (sext(imm) << 2).
  - j: {PC+4[31:28], target, 2'b00}.
- data_out = rt at all times. data_addr = ALU result at all times.

## Timing
- All decode, ALU and next-PC logic is combinational within the cycle. Every instruction has latency 1 clock.
- PC and the register file update on the rising clk edge. A register written in cycle N is visible to the instruction fetched in cycle N+1.
- Reset while rst is high (asynchronous):
  - PC = RESET_PC and every register = 0.
  - mem_read = 0 and mem_write = 0, forced regardless of instruction.
  - instruction_addr = RESET_PC.
- On the first rising edge after rst falls, the instruction at RESET_PC completes.
- Reset asserted mid-instruction aborts that instruction. No register or memory write occurs on an edge where rst is high.
- PC wraps modulo 2^32.
- A beq back to itself (imm = -1) spins forever; this is a legal halt idiom.

## Structure
- Shared package holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - funct constants;
  - an ALU-op enum: ADD, SUB, AND, OR, SLT.
- One natural sub-module, regfile: 2 read ports, 1 write port, async reset.
- The ALU and control decode live inline in cpu.

## Test plan
- Reset:
  - Assert rst from 5 ns to 10 ns with a 10 ns clk period.
  - Required: instruction_addr = 0, mem_read = 0 and mem_write = 0 during reset.
  - Required: the PC reads 0, 4, 8 on successive edges afterwards.
- ALU sequence:
  - Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sub r4,r1,r2; and r5,r1,r2; or r6,r1,r2; slt r7,r2,r1.
  - Required: r3 = 2, r4 = 8, r5 = 5, r6 = 0xFFFF_FFFD, r7 = 1.
- Memory:
  - Program addi r1,r0,0x40; addi r2,r0,0x1234; sw r2,4(r1); lw r3,4(r1).
  - Required during sw: data_addr = 0x44, data_out = 0x1234, mem_write = 1.
  - Required: r3 = 0x1234 and mem_read = 1 during lw.
- Control flow:
  - beq r0,r0,+2 at PC 0x10 → next PC = 0x1C.
  - beq r1,r0 with r1 ≠ 0 → PC+4.
  - j 0x40 (target = 0x10) at PC 0x1C → next PC = 0x40.
- r0 protection: addi r0,r0,7 then add r1,r0,r0 → r1 = 0.
- Mid-run reset: pulse rst during a sw → no memory write on that edge, PC = 0, all registers = 0.
